// File: rtl/mymax_bus_master.sv
// mymax_bus_master
//   Hardware initiator for the Din/Cin/Dout/Cout req-ack peripheral protocol.
//   It takes an operand pair from a valid/ready command port and runs this sequence on the
//   per_* bus:
//     Din=a, Cin=1, poll Cout==1, Din=b, Cin=0, poll Cout==0,
//     Cin=1, poll Cout==1, read Dout, Cin=0, poll Cout==0.
//   The value read from Dout is returned on a valid/ready response port.
//
// Ports
//   mclk, puc_rst          clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_a/cmd_b are latched on acceptance
//   rsp_valid/rsp_ready    response handshake; rsp_data = Dout value, rsp_err = poll timeout
//   timeout_err            sticky timeout flag, cleared only by puc_rst
//   per_addr/per_din/per_en/per_we  peripheral access (we=11 write, 00 read)
//   per_dout               combinational read data, sampled in the access cycle
module mymax_bus_master #(
    parameter logic [13:0] BASE_ADDR  = 14'hA0,
    parameter logic [15:0] POLL_LIMIT = 16'd1023
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        timeout_err,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    localparam logic [13:0] ADDR_DIN  = BASE_ADDR;
    localparam logic [13:0] ADDR_CIN  = BASE_ADDR + 14'd1;
    localparam logic [13:0] ADDR_DOUT = BASE_ADDR + 14'd2;
    localparam logic [13:0] ADDR_COUT = BASE_ADDR + 14'd3;

    typedef enum logic [3:0] {
        StIdle,
        StWrA,
        StC1A,
        StP1A,
        StWrB,
        StC0A,
        StP0A,
        StC1B,
        StP1B,
        StRd,
        StC0B,
        StP0B,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [13:0] per_addr_q, per_addr_d;
    logic [15:0] per_din_q, per_din_d;
    logic        per_en_q, per_en_d;
    logic [1:0]  per_we_q, per_we_d;

    // Poll-state decode: which Cout value ends the poll and where to go next.
    logic        poll_expect;
    state_e      poll_next;
    logic [15:0] poll_cnt_inc;

    always_comb begin
        poll_expect = 1'b0;
        poll_next   = StIdle;
        case (state_q)
            StP1A: begin poll_expect = 1'b1; poll_next = StWrB;  end
            StP0A: begin poll_expect = 1'b0; poll_next = StC1B;  end
            StP1B: begin poll_expect = 1'b1; poll_next = StRd;   end
            StP0B: begin poll_expect = 1'b0; poll_next = StDone; end
            default: ;
        endcase
        poll_cnt_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
    end

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        timeout_err_d = timeout_err_q;
        poll_cnt_d    = poll_cnt_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    rsp_data_d = 16'h0;
                    rsp_err_d  = 1'b0;
                    state_d    = StWrA;
                end
            end
            StWrA: state_d = StC1A;
            StC1A: state_d = StP1A;
            StWrB: state_d = StC0A;
            StC0A: state_d = StP0A;
            StC1B: state_d = StP1B;
            StRd: begin
                rsp_data_d = per_dout;
                state_d    = StC0B;
            end
            StC0B: state_d = StP0B;
            StP1A, StP0A, StP1B, StP0B: begin
                // Only Cout bit 0 carries the handshake.
                if (per_dout[0] == poll_expect) begin
                    state_d = poll_next;
                end else if (poll_cnt_inc >= POLL_LIMIT) begin
                    state_d       = StDone;
                    rsp_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    rsp_data_d    = 16'h0;
                end else begin
                    poll_cnt_d = poll_cnt_inc;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Any state change restarts the count, so every poll phase starts from zero.
        if (state_d != state_q) begin
            poll_cnt_d = 16'h0;
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StDone);
        per_en_d    = 1'b0;
        per_we_d    = 2'b00;
        per_addr_d  = 14'h0;
        per_din_d   = 16'h0;
        case (state_d)
            StWrA: begin
                per_en_d = 1'b1; per_we_d = 2'b11; per_addr_d = ADDR_DIN; per_din_d = a_d;
            end
            StWrB: begin
                per_en_d = 1'b1; per_we_d = 2'b11; per_addr_d = ADDR_DIN; per_din_d = b_d;
            end
            StC1A, StC1B: begin
                per_en_d = 1'b1; per_we_d = 2'b11; per_addr_d = ADDR_CIN; per_din_d = 16'h1;
            end
            StC0A, StC0B: begin
                per_en_d = 1'b1; per_we_d = 2'b11; per_addr_d = ADDR_CIN; per_din_d = 16'h0;
            end
            StP1A, StP0A, StP1B, StP0B: begin
                per_en_d = 1'b1; per_addr_d = ADDR_COUT;
            end
            StRd: begin
                per_en_d = 1'b1; per_addr_d = ADDR_DOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q       <= StIdle;
            a_q           <= 16'h0;
            b_q           <= 16'h0;
            rsp_data_q    <= 16'h0;
            rsp_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            poll_cnt_q    <= 16'h0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            per_addr_q    <= 14'h0;
            per_din_q     <= 16'h0;
            per_en_q      <= 1'b0;
            per_we_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            timeout_err_q <= timeout_err_d;
            poll_cnt_q    <= poll_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            per_addr_q    <= per_addr_d;
            per_din_q     <= per_din_d;
            per_en_q      <= per_en_d;
            per_we_q      <= per_we_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign timeout_err = timeout_err_q;
    assign per_addr    = per_addr_q;
    assign per_din     = per_din_q;
    assign per_en      = per_en_q;
    assign per_we      = per_we_q;

endmodule
